mc_controller: RTL
==================

# mc_controller

Multi-cycle control FSM for the MIPS datapath (PC, IM, GRF, ALU, EXT, DM). It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath enable and mux select, so the GRF, ALU and DM are shared across cycles instead of being duplicated per stage. Data-memory accesses use a req/ready handshake so a slow DM can stretch the MEM state without corrupting architectural state.

## Interface
- No parameters; encodings below are fixed.
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- instr  in  32  IM output for current PC; sampled only at end of FETCH
- zero  in  1  ALU equality flag (rs == rt), valid in EXEC
- mem_ready  in  1  DM completion; sampled only in MEM
- pc_we  out  1  PC load enable
- npc_sel  out  2  0 PC+4, 1 branch (PC+4+imm<<2), 2 jump target, 3 GRF rs
- grf_we  out  1  GRF write enable
- grf_wsel  out  2  write address: 0 rt, 1 rd, 2 $31
- grf_dsel  out  2  write data: 0 ALU, 1 DM, 2 PC+4
- alu_srcb  out  1  0 RD2, 1 extended immediate
- alu_op  out  3  0 add, 1 sub, 2 or, 3 lui (imm<<16)
- ext_op  out  1  0 zero-extend, 1 sign-extend
- mem_req  out  1  DM access request
- mem_we  out  1  DM write (valid only with mem_req)
- illegal  out  1  one-cycle pulse on undecodable instruction
- state  out  3  current state (debug probe)

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Internal op/funct register loaded from instr on FETCH->DECODE edge; later decode uses the latched copy only.
- All outputs are combinational from state + latched op, then forced to 0 while reset=1. state resets to FETCH; op register resets to 0 (nop).
- add (op 000000/funct 100000), sub (funct 100010): F,D,E,W. WB: grf_we=1, grf_wsel=1, grf_dsel=0, pc_we=1, npc_sel=0.
- ori (001101): F,D,E,W; ext_op=0, alu_srcb=1, alu_op=2; WB writes rt.
- lui (001111): F,D,E,W; alu_op=3, alu_srcb=1; WB writes rt.
- lw (100011): F,D,E,M,W; ext_op=1, alu_srcb=1, alu_op=0 held E through W; M: mem_req=1, mem_we=0; WB: grf_dsel=1, grf_wsel=0, pc_we=1.
- sw (101011): F,D,E,M; M: mem_req=1, mem_we=1; leaving M: pc_we=1, npc_sel=0.
- beq (000100): F,D,E; EXEC: alu_op=1, pc_we=1, npc_sel = zero ? 1 : 0.
- jal (000011): F,D; DECODE: grf_we=1, grf_wsel=2, grf_dsel=2, pc_we=1, npc_sel=2.
- jr (000000/001000): F,D; DECODE: pc_we=1, npc_sel=3.
- nop (instr==0): F,D; DECODE: pc_we=1, npc_sel=0.
- Any other encoding: F,D; DECODE: illegal=1, pc_we=1, npc_sel=0, no other enables.
- Invariant: pc_we asserted exactly once per instruction, in its final cycle; grf_we at most once.

## Timing
- Latency per instruction: jal/jr/nop/illegal 2, beq 3, R/ori/lui 4, sw 4+w, lw 5+w; w = extra cycles mem_ready is low in MEM.
- MEM handshake: mem_req/mem_we held constant every MEM cycle; leave MEM on the first edge where mem_ready=1 (same cycle as entry gives w=0). mem_ready ignored in other states.
- mem_req never asserted outside MEM; mem_we=1 only with mem_req=1.
- Reset mid-instruction (incl. during MEM wait): outputs 0 in the reset cycle, FETCH next cycle, no partial GRF/PC write.
- instr changes outside the FETCH sampling edge have no effect.

## Configuration
- MCTRL_PERF_EN defined: adds outputs cycle_cnt[31:0] (increments every non-reset cycle) and retire_cnt[31:0] (increments on each pc_we=1 cycle); both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; control behaviour identical.

## Test plan
- add $3,$1,$2 (0x00221820) -> states 0,1,2,4; grf_we=1 with grf_wsel=1 only in cycle 4; pc_we once.
- lw (0x8C220004) with mem_ready low 3 cycles -> MEM held 4 cycles, mem_req=1/mem_we=0 throughout, WB grf_dsel=1; total 8 cycles.
- beq (0x10220003) with zero=1 then zero=0 -> EXEC npc_sel=1 then 0; 3 cycles each.
- jal (0x0C000C00) -> DECODE grf_we=1, grf_wsel=2, grf_dsel=2, npc_sel=2; next state FETCH.
- Reset asserted in 2nd cycle of sw MEM wait -> all outputs 0 that cycle, state=0 next, no mem_we after reset.
- instr 0xFC000000 -> illegal=1 for exactly one cycle, pc_we=1, npc_sel=0; with MCTRL_PERF_EN retire_cnt increments by 1.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath enables/selects.
// Optional MCTRL_PERF_EN adds cycle_cnt_o / retire_cnt_o performance counters.
module mc_controller (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] instr_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_we_o,
    output logic [1:0]  npc_sel_o,
    output logic        grf_we_o,
    output logic [1:0]  grf_wsel_o,
    output logic [1:0]  grf_dsel_o,
    output logic        alu_srcb_o,
    output logic [2:0]  alu_op_o,
    output logic        ext_op_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        illegal_o,
`ifdef MCTRL_PERF_EN
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] retire_cnt_o,
`endif
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ADD, C_SUB, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_JR, C_ILL
    } cls_t;

    state_t state_q, state_d;
    cls_t   cls_q, cls_d, dec;
    logic   alu_en;

    // Decode the IM word once; later states only look at the latched class.
    always_comb begin
        dec = C_ILL;
        if (instr_i == 32'h0) begin
            dec = C_NOP;
        end else begin
            case (instr_i[31:26])
                6'b000000: begin
                    case (instr_i[5:0])
                        6'b100000: dec = C_ADD;
                        6'b100010: dec = C_SUB;
                        6'b001000: dec = C_JR;
                        default:   dec = C_ILL;
                    endcase
                end
                6'b001101: dec = C_ORI;
                6'b001111: dec = C_LUI;
                6'b100011: dec = C_LW;
                6'b101011: dec = C_SW;
                6'b000100: dec = C_BEQ;
                6'b000011: dec = C_JAL;
                default:   dec = C_ILL;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_FETCH;
            cls_q   <= C_NOP;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        alu_en     = 1'b0;
        pc_we_o    = 1'b0;
        npc_sel_o  = 2'd0;
        grf_we_o   = 1'b0;
        grf_wsel_o = 2'd0;
        grf_dsel_o = 2'd0;
        alu_srcb_o = 1'b0;
        alu_op_o   = 3'd0;
        ext_op_o   = 1'b0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        illegal_o  = 1'b0;
        state_o    = state_q;

        case (state_q)
            S_FETCH: begin
                cls_d   = dec;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (cls_q)
                    C_JAL: begin
                        grf_we_o   = 1'b1;
                        grf_wsel_o = 2'd2;
                        grf_dsel_o = 2'd2;
                        pc_we_o    = 1'b1;
                        npc_sel_o  = 2'd2;
                    end
                    C_JR: begin
                        pc_we_o   = 1'b1;
                        npc_sel_o = 2'd3;
                    end
                    C_NOP: pc_we_o = 1'b1;
                    C_ILL: begin
                        pc_we_o   = 1'b1;
                        illegal_o = 1'b1;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                alu_en = 1'b1;
                case (cls_q)
                    C_BEQ: begin
                        pc_we_o   = 1'b1;
                        npc_sel_o = {1'b0, zero_i};
                        state_d   = S_FETCH;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                // Request stays flat across wait cycles; only the exit depends on mem_ready_i.
                alu_en    = 1'b1;
                mem_req_o = 1'b1;
                mem_we_o  = (cls_q == C_SW);
                if (mem_ready_i) begin
                    if (cls_q == C_SW) begin
                        pc_we_o = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                alu_en   = 1'b1;
                grf_we_o = 1'b1;
                pc_we_o  = 1'b1;
                state_d  = S_FETCH;
                case (cls_q)
                    C_ADD, C_SUB: grf_wsel_o = 2'd1;
                    C_LW:         grf_dsel_o = 2'd1;
                    default:      grf_wsel_o = 2'd0;
                endcase
            end
            default: state_d = S_FETCH;
        endcase

        if (alu_en) begin
            case (cls_q)
                C_SUB, C_BEQ: alu_op_o = 3'd1;
                C_ORI: begin
                    alu_srcb_o = 1'b1;
                    alu_op_o   = 3'd2;
                end
                C_LUI: begin
                    alu_srcb_o = 1'b1;
                    alu_op_o   = 3'd3;
                end
                C_LW, C_SW: begin
                    alu_srcb_o = 1'b1;
                    ext_op_o   = 1'b1;
                end
                default: alu_op_o = 3'd0;
            endcase
        end

        // Reset cycle must not leak a partial PC/GRF/DM write.
        if (reset_i) begin
            pc_we_o    = 1'b0;
            npc_sel_o  = 2'd0;
            grf_we_o   = 1'b0;
            grf_wsel_o = 2'd0;
            grf_dsel_o = 2'd0;
            alu_srcb_o = 1'b0;
            alu_op_o   = 3'd0;
            ext_op_o   = 1'b0;
            mem_req_o  = 1'b0;
            mem_we_o   = 1'b0;
            illegal_o  = 1'b0;
            state_o    = 3'd0;
        end
    end

`ifdef MCTRL_PERF_EN
    logic [31:0] cycle_q, retire_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cycle_q  <= 32'd0;
            retire_q <= 32'd0;
        end else begin
            cycle_q  <= cycle_q + 32'd1;
            retire_q <= retire_q + {31'd0, pc_we_o};
        end
    end

    assign cycle_cnt_o  = cycle_q;
    assign retire_cnt_o = retire_q;
`endif

endmodule
